// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, multi-cycle multiply/divide hold,
// taken-branch flushes, plus saturating stall and flush performance counters.
module hazard_controller #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RegisterRs,
    input  logic [4:0]       ID_RegisterRt,
    input  logic             ID_UsesRt,
    input  logic             ID_MdOp,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RegisterRt,
    input  logic             MEM_BranchTaken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             md_go,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]       MD_LOAD = 4'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             load_use;

    // Register $zero is never a real dependency, so a load targeting it cannot stall.
    assign load_use = EX_MemRead && (EX_RegisterRt != 5'd0) &&
                      ((EX_RegisterRt == ID_RegisterRs) ||
                       (ID_UsesRt && (EX_RegisterRt == ID_RegisterRt)));

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned and no latch is inferred.
        PC_Write      = 1'b1;
        IFID_Write    = 1'b1;
        IDEX_Write    = 1'b1;
        IDEX_Bubble   = 1'b0;
        EXMEM_Bubble  = 1'b0;
        IFID_Flush    = 1'b0;
        IDEX_Flush    = 1'b0;
        EXMEM_Flush   = 1'b0;
        md_go         = 1'b0;
        md_busy       = (state_q == MD_WAIT) && !rst_i;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (rst_i) begin
            state_d  = RUN;
            md_cnt_d = 4'd0;
        end else if (MEM_BranchTaken) begin
            // A taken branch squashes everything younger, including an in-flight MD op.
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            state_d     = RUN;
            md_cnt_d    = 4'd0;
        end else if (state_q == MD_WAIT) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            md_cnt_d     = md_cnt_q - 4'd1;
            if (md_cnt_q <= 4'd1) begin
                state_d  = RUN;
                md_cnt_d = 4'd0;
            end
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (ID_MdOp) begin
            md_go    = 1'b1;
            state_d  = MD_WAIT;
            md_cnt_d = MD_LOAD;
        end

        if (!rst_i) begin
            if (!PC_Write && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
            if (MEM_BranchTaken && (flush_count_q != CNT_MAX)) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            md_cnt_q      <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 8, meaning EX-stage cycles a multiply/divide occupies (legal 2..15).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ID_RegisterRs, ID_RegisterRt  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port ID_UsesRt  input  1  ID instruction reads Rt as a source.
REQ-007 SHALL have port ID_MdOp  input  1  ID instruction is a multiply/divide.
REQ-008 SHALL have ports EX_MemRead (1) and EX_RegisterRt (5), inputs, identifying a load in EX and its destination.
REQ-009 SHALL have port MEM_BranchTaken  input  1  branch in MEM resolved taken.
REQ-010 SHALL have outputs PC_Write, IFID_Write, IDEX_Write (1 each): register enables, 1 = advance.
REQ-011 SHALL have outputs IDEX_Bubble, EXMEM_Bubble (1 each): zero control fields entering that register.
REQ-012 SHALL have outputs IFID_Flush, IDEX_Flush, EXMEM_Flush (1 each): squash the register contents.
REQ-013 SHALL have outputs md_go (1, start pulse to MD unit), md_busy (1), stall_count and flush_count (CNT_W each).

Function
REQ-014 SHALL implement states RUN and MD_WAIT plus a 4-bit down-counter md_cnt.
REQ-015 Default outputs: all Write = 1; all Bubble, Flush, md_go = 0.
REQ-016 Priority, highest first: MEM_BranchTaken, MD_WAIT hold, load-use, md issue.
REQ-017 MEM_BranchTaken = 1, any state: IFID_Flush = IDEX_Flush = EXMEM_Flush = 1; PC_Write = 1; md_go = 0; next state RUN; md_cnt cleared (in-flight MD op aborted).
REQ-018 Load-use hazard = EX_MemRead & EX_RegisterRt != 0 & (EX_RegisterRt == ID_RegisterRs | (ID_UsesRt & EX_RegisterRt == ID_RegisterRt)).
REQ-019 RUN with load-use: PC_Write = IFID_Write = 0, IDEX_Bubble = 1 for exactly that cycle; md_go suppressed even if ID_MdOp.
REQ-020 RUN, ID_MdOp = 1, no branch, no load-use: md_go = 1 that cycle; next state MD_WAIT; md_cnt loaded with MD_LATENCY-1.
REQ-021 MD_WAIT: PC_Write = IFID_Write = IDEX_Write = 0; EXMEM_Bubble = 1; md_busy = 1; md_cnt decrements each cycle.
REQ-022 MD_WAIT with md_cnt == 1: next state RUN; MD op leaves EX on the following cycle (total EX occupancy MD_LATENCY cycles).
REQ-023 Load-use hazards during MD_WAIT SHALL be ignored (hold already covers them).
REQ-024 stall_count SHALL increment on every cycle with PC_Write = 0, saturating at all-ones.
REQ-025 flush_count SHALL increment on every cycle with MEM_BranchTaken = 1, saturating at all-ones.
REQ-026 Outputs other than counters and md_busy SHALL be combinational from state and current inputs; zero-cycle latency.
REQ-027 ID_RegisterRs == 0 or Rt == 0 SHALL never cause a load-use stall.

Reset
REQ-028 rst_i = 1 at a clock edge: state RUN, md_cnt = 0, stall_count = 0, flush_count = 0.
REQ-029 While rst_i = 1: all hazard inputs ignored, outputs at REQ-015 defaults, md_busy = 0.
REQ-030 rst_i asserted mid-MD_WAIT SHALL abort the MD op; no md_go reissued after release.

Verification
REQ-031 Load EX_RegisterRt=5, ID_RegisterRs=5 -> one cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1; stall_count 0->1; next cycle defaults.
REQ-032 EX_RegisterRt=0 with ID_RegisterRs=0, EX_MemRead=1 -> no stall; ID_UsesRt=0, ID_RegisterRt=5=EX_RegisterRt -> no stall.
REQ-033 ID_MdOp=1 with MD_LATENCY=8 -> md_go one cycle, md_busy high 7 cycles, stall_count = 7, then defaults.
REQ-034 MEM_BranchTaken=1 at third MD_WAIT cycle -> three flushes that cycle, md_busy low next cycle, flush_count = 1.
REQ-035 ID_MdOp=1 and load-use together -> stall only, md_go=0; md_go asserted the next cycle.
REQ-036 rst_i pulsed mid-MD_WAIT with counters nonzero -> state RUN, all counts 0, md_busy 0 after the edge.
